// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writes, picks a bypass tap
// for each source operand and holds issue on RAW, WAW or writeback-port hazards.
module forwarding_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int LW = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic                  issue_reg_write_en,
  input  logic                  issue_long_en,
  input  logic [LW-1:0]         issue_lat_i,
  input  logic [NUM_SRC*AW-1:0] issue_rs_i,
  input  logic                  flush_i,
  output logic [NUM_SRC*LW-1:0] fwd_optn_o,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic [31:0]           stall_cnt_o
);

  localparam logic [LW-1:0] LAT_ONE = LW'(1);
  localparam logic [LW-1:0] LAT_MAX = LW'(MAX_LAT);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] long_q, long_d;
  logic [LW-1:0]       cnt_q [NUM_REGS];
  logic [LW-1:0]       cnt_d [NUM_REGS];
  logic [31:0]         stall_cnt_q, stall_cnt_d;

  logic [LW-1:0] eff_lat;
  logic          writes_rd;
  logic          raw_stall;
  logic          waw_stall;
  logic          wb_stall;
  logic          accept;

  // Clamp the requested latency into the legal 1..MAX_LAT range
  always_comb begin
    eff_lat = issue_lat_i;
    if (issue_lat_i == '0) begin
      eff_lat = LAT_ONE;
    end else if (issue_lat_i > LAT_MAX) begin
      eff_lat = LAT_MAX;
    end
  end

  // Per-operand bypass select from pre-update state; long producers only reach the WB tap
  always_comb begin
    fwd_optn_o = '0;
    raw_stall  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (issue_rs_i[s*AW +: AW] != '0 && busy_q[issue_rs_i[s*AW +: AW]]) begin
        if (!long_q[issue_rs_i[s*AW +: AW]]) begin
          fwd_optn_o[s*LW +: LW] = cnt_q[issue_rs_i[s*AW +: AW]];
        end else if (cnt_q[issue_rs_i[s*AW +: AW]] == LAT_ONE) begin
          fwd_optn_o[s*LW +: LW] = LAT_ONE;
        end else begin
          raw_stall = 1'b1;
        end
      end
    end
  end

  // Destination hazards: an older write landing after ours, or two writes sharing one WB slot
  always_comb begin
    writes_rd = issue_reg_write_en && (issue_rd_i != '0);
    waw_stall = writes_rd && busy_q[issue_rd_i] && (cnt_q[issue_rd_i] > eff_lat);
    wb_stall  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (writes_rd && busy_q[r] && (cnt_q[r] == eff_lat)) begin
        wb_stall = 1'b1;
      end
    end
    issue_ready_o = !(raw_stall || waw_stall || wb_stall);
    accept        = issue_valid_i && issue_ready_o && !flush_i;
  end

  // Next scoreboard state: count down, record a new producer, flush wipes everything
  always_comb begin
    busy_d = busy_q;
    long_d = long_q;
    cnt_d  = cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (busy_q[r]) begin
        if (cnt_q[r] == LAT_ONE) begin
          busy_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end else begin
          cnt_d[r] = cnt_q[r] - LAT_ONE;
        end
      end
    end
    if (accept && writes_rd) begin
      busy_d[issue_rd_i] = 1'b1;
      cnt_d[issue_rd_i]  = eff_lat;
      long_d[issue_rd_i] = issue_long_en;
    end
    if (flush_i) begin
      busy_d = '0;
      long_d = '0;
      cnt_d  = '{default: '0};
    end
  end

  // Saturating count of cycles an instruction was held back
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid_i && !issue_ready_o && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      long_q      <= '0;
      cnt_q       <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      long_q      <= long_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Testbench for forwarding_scoreboard: directed hazard scenarios followed by
// random traffic, all compared against a cycles-remaining reference model.
module tb_forwarding_scoreboard;

  localparam int NREG = 32;
  localparam int NSRC = 2;
  localparam int MLAT = 4;
  localparam int AW   = 5;
  localparam int LW   = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [AW-1:0]        issue_rd;
  logic                 issue_we;
  logic                 issue_long;
  logic [LW-1:0]        issue_lat;
  logic [NSRC*AW-1:0]   issue_rs;
  logic                 flush;
  logic [NSRC*LW-1:0]   fwd_optn;
  logic [NREG-1:0]      busy;
  logic [31:0]          stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: cycles left until each register's write lands (0 = idle)
  int          rem [NREG];
  bit          lm  [NREG];
  logic [31:0] stall_m;
  bit          m_ready;

  int cur_rd, cur_lat, cur_rs0, cur_rs1;
  bit cur_v, cur_we, cur_long, cur_flush;

  forwarding_scoreboard #(.NUM_REGS(NREG), .NUM_SRC(NSRC), .MAX_LAT(MLAT)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .issue_valid_i      (issue_valid),
    .issue_ready_o      (issue_ready),
    .issue_rd_i         (issue_rd),
    .issue_reg_write_en (issue_we),
    .issue_long_en      (issue_long),
    .issue_lat_i        (issue_lat),
    .issue_rs_i         (issue_rs),
    .flush_i            (flush),
    .fwd_optn_o         (fwd_optn),
    .busy_o             (busy),
    .stall_cnt_o        (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int effLat(input int lat);
    if (lat == 0) return 1;
    if (lat > MLAT) return MLAT;
    return lat;
  endfunction

  task automatic clearModel();
    for (int r = 0; r < NREG; r++) begin
      rem[r] = 0;
      lm[r]  = 1'b0;
    end
    stall_m = '0;
  endtask

  // Compare live outputs with the model; negative expectations mean "model only"
  task automatic checkOutput(input string tag, input int exp_ready, input int exp_fwd0);
    logic [NSRC*LW-1:0] e_fwd;
    logic [NREG-1:0]    e_busy;
    bit                 raw, hz;
    int                 rs, sel, l;
    raw   = 1'b0;
    e_fwd = '0;
    for (int s = 0; s < NSRC; s++) begin
      rs  = (s == 0) ? cur_rs0 : cur_rs1;
      sel = 0;
      if (rs != 0 && rem[rs] > 0) begin
        if (!lm[rs]) sel = rem[rs];
        else if (rem[rs] == 1) sel = 1;
        else raw = 1'b1;
      end
      e_fwd[s*LW +: LW] = 3'(sel);
    end
    l  = effLat(cur_lat);
    hz = 1'b0;
    if (cur_we && cur_rd != 0) begin
      if (rem[cur_rd] > l) hz = 1'b1;
      for (int r = 0; r < NREG; r++) if (rem[r] == l) hz = 1'b1;
    end
    m_ready = !raw && !hz;
    for (int r = 0; r < NREG; r++) e_busy[r] = (rem[r] > 0);

    vectors++;
    assert (issue_ready === m_ready) else begin
      miscompares++;
      $error("[TB] FAIL %s ready: got %b want %b", tag, issue_ready, m_ready);
    end
    vectors++;
    assert (fwd_optn === e_fwd) else begin
      miscompares++;
      $error("[TB] FAIL %s fwd_optn: got %h want %h", tag, fwd_optn, e_fwd);
    end
    vectors++;
    assert (busy === e_busy) else begin
      miscompares++;
      $error("[TB] FAIL %s busy: got %h want %h", tag, busy, e_busy);
    end
    vectors++;
    assert (stall_cnt === stall_m) else begin
      miscompares++;
      $error("[TB] FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, stall_m);
    end
    if (exp_ready >= 0) begin
      vectors++;
      assert (issue_ready === 1'(exp_ready)) else begin
        miscompares++;
        $error("[TB] FAIL %s directed ready: got %b want %0d", tag, issue_ready, exp_ready);
      end
    end
    if (exp_fwd0 >= 0) begin
      vectors++;
      assert (fwd_optn[LW-1:0] === 3'(exp_fwd0)) else begin
        miscompares++;
        $error("[TB] FAIL %s directed fwd0: got %0d want %0d", tag, fwd_optn[LW-1:0], exp_fwd0);
      end
    end
  endtask

  // One cycle: drive at negedge, check mid-cycle, then advance the model at posedge
  task automatic applyStimulus(input string tag, input bit v, input bit we, input bit lng,
                               input int rd, input int lat, input int rs0, input int rs1,
                               input bit fl, input int exp_ready, input int exp_fwd0);
    int l;
    @(negedge clk);
    cur_v = v; cur_we = we; cur_long = lng; cur_rd = rd; cur_lat = lat;
    cur_rs0 = rs0; cur_rs1 = rs1; cur_flush = fl;
    issue_valid = v;
    issue_we    = we;
    issue_long  = lng;
    issue_rd    = 5'(rd);
    issue_lat   = 3'(lat);
    issue_rs    = {5'(rs1), 5'(rs0)};
    flush       = fl;
    #1;
    checkOutput(tag, exp_ready, exp_fwd0);
    @(posedge clk);
    l = effLat(cur_lat);
    if (cur_v && !m_ready && !cur_flush && stall_m != '1) stall_m = stall_m + 32'd1;
    if (cur_flush) begin
      for (int r = 0; r < NREG; r++) rem[r] = 0;
    end else begin
      for (int r = 0; r < NREG; r++) if (rem[r] > 0) rem[r]--;
      if (cur_v && m_ready && cur_we && cur_rd != 0) begin
        rem[cur_rd] = l;
        lm[cur_rd]  = cur_long;
      end
    end
  endtask

  task automatic checkReset(input string tag);
    vectors++;
    assert (issue_ready === 1'b1) else begin
      miscompares++;
      $error("[TB] FAIL %s ready: got %b want 1", tag, issue_ready);
    end
    vectors++;
    assert (fwd_optn === '0) else begin
      miscompares++;
      $error("[TB] FAIL %s fwd_optn: got %h want 0", tag, fwd_optn);
    end
    vectors++;
    assert (busy === '0) else begin
      miscompares++;
      $error("[TB] FAIL %s busy: got %h want 0", tag, busy);
    end
    vectors++;
    assert (stall_cnt === '0) else begin
      miscompares++;
      $error("[TB] FAIL %s stall_cnt: got %0d want 0", tag, stall_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", 0, 0, 0, 0, 1, 0, 0, 0, -1, -1);
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_long = 1'b0;
    issue_rd = '0; issue_lat = 3'd1; issue_rs = '0; flush = 1'b0;
    cur_v = 0; cur_we = 0; cur_long = 0; cur_rd = 0; cur_lat = 1;
    cur_rs0 = 0; cur_rs1 = 0; cur_flush = 0;
    clearModel();
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU producer forwarded from tap 2, then tap 1, then the register file
    applyStimulus("alu_issue", 1, 1, 0, 5, 2, 0, 0, 0, 1, -1);
    applyStimulus("alu_tap2",  1, 0, 0, 0, 1, 5, 0, 0, 1, 2);
    applyStimulus("alu_tap1",  1, 0, 0, 0, 1, 5, 0, 0, 1, 1);
    applyStimulus("alu_rf",    1, 0, 0, 0, 1, 5, 0, 0, 1, 0);

    // Long producer stalls its consumer until it reaches the writeback tap
    applyStimulus("long_issue", 1, 1, 1, 7, 3, 0, 0, 0, 1, -1);
    applyStimulus("long_raw3",  1, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    applyStimulus("long_raw2",  1, 0, 0, 0, 1, 0, 7, 0, 0, -1);
    applyStimulus("long_wb",    1, 0, 0, 0, 1, 7, 0, 0, 1, 1);
    idle(2);

    // Writeback-port conflict, then a WAW conflict
    applyStimulus("wb_prod",  1, 1, 0, 4, 2, 0, 0, 0, 1, -1);
    applyStimulus("wb_clash", 1, 1, 0, 9, 2, 0, 0, 0, 0, -1);
    applyStimulus("waw_prod", 1, 1, 0, 3, 4, 0, 0, 0, 1, -1);
    applyStimulus("waw_clash", 1, 1, 0, 3, 1, 0, 0, 0, 0, -1);
    idle(4);

    // x0 is never tracked; latency clamping at both ends
    applyStimulus("x0_write",  1, 1, 0, 0, 1, 0, 0, 0, 1, -1);
    applyStimulus("x0_read",   1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("lat0",      1, 1, 0, 6, 0, 0, 0, 0, 1, -1);
    applyStimulus("lat0_read", 1, 0, 0, 0, 1, 6, 0, 0, 1, 1);
    applyStimulus("lat7",      1, 1, 0, 8, 7, 0, 0, 0, 1, -1);
    applyStimulus("lat7_read", 1, 0, 0, 0, 1, 8, 0, 0, 1, 4);
    idle(4);

    // Flush with a same-cycle issue
    applyStimulus("fl_p1", 1, 1, 0, 10, 4, 0, 0, 0, 1, -1);
    applyStimulus("fl_p2", 1, 1, 0, 11, 2, 0, 0, 0, 1, -1);
    applyStimulus("fl_p3", 1, 1, 1, 12, 4, 0, 0, 0, 1, -1);
    applyStimulus("flush", 1, 1, 0, 13, 1, 0, 0, 1, -1, -1);
    applyStimulus("post_flush", 1, 0, 0, 0, 1, 13, 10, 0, 1, 0);

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 9) < 8), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    ($urandom_range(0, 19) == 0), -1, -1);
      if (i == 200) begin
        applyStimulus("pre_rst", 1, 1, 1, 2, 4, 0, 0, 0, -1, -1);
        @(negedge clk);
        issue_valid = 1'b0; issue_we = 1'b0; flush = 1'b0;
        cur_v = 0; cur_we = 0; cur_flush = 0;
        #1 rst_n = 1'b0;
        #1 checkReset("mid_reset");
        clearModel();
        #1 rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
